// File: rtl/sfx_scheduler_if.sv
// ----------------------------------------------------------------------------
// sfx_scheduler_if
//   Bundle between the game FSM (master) and the buzzer sequencer (slave).
//
//   Signals
//     i_charge      game -> sched  level, button held and man squeezing
//     i_charge_lvl  game -> sched  squeeze level 0-14 (15 tolerated)
//     i_land_ok     game -> sched  one-cycle pulse, landed on block
//     i_land_fail   game -> sched  one-cycle pulse, missed block
//     i_gameover    game -> sched  one-cycle pulse, game over
//     i_mute        game -> sched  silence the buzzer (only with SFX_MUTE_EN)
//     o_scale       sched -> game  note index to buzzer, 0 = silence
//     o_beep_en     sched -> game  buzzer enable
//     o_busy        sched -> game  melody in progress
//     o_src         sched -> game  0 none, 1 charge, 2 land, 3 gameover
//
//   Optional macro: SFX_MUTE_EN adds i_mute.
// ----------------------------------------------------------------------------
interface sfx_scheduler_if;
  logic       i_charge;
  logic [3:0] i_charge_lvl;
  logic       i_land_ok;
  logic       i_land_fail;
  logic       i_gameover;
`ifdef SFX_MUTE_EN
  logic       i_mute;
`endif
  logic [3:0] o_scale;
  logic       o_beep_en;
  logic       o_busy;
  logic [1:0] o_src;

`ifdef SFX_MUTE_EN
  modport master (
    output i_charge, i_charge_lvl, i_land_ok, i_land_fail, i_gameover, i_mute,
    input  o_scale, o_beep_en, o_busy, o_src
  );
  modport slave (
    input  i_charge, i_charge_lvl, i_land_ok, i_land_fail, i_gameover, i_mute,
    output o_scale, o_beep_en, o_busy, o_src
  );
`else
  modport master (
    output i_charge, i_charge_lvl, i_land_ok, i_land_fail, i_gameover,
    input  o_scale, o_beep_en, o_busy, o_src
  );
  modport slave (
    input  i_charge, i_charge_lvl, i_land_ok, i_land_fail, i_gameover,
    output o_scale, o_beep_en, o_busy, o_src
  );
`endif
endinterface

// File: rtl/sfx_scheduler.sv
// ----------------------------------------------------------------------------
// sfx_scheduler
//   Arbiter and note sequencer for the shared piezo buzzer. Chooses between
//   the charge tone (follows squeeze level), the landing jingles (hit/miss)
//   and the game-over melody by fixed priority, and steps short note ROMs at
//   a fixed note rate.
//
//   Ports
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    sfx_scheduler_if.slave (see interface file for signal list)
//
//   Parameters
//     NOTE_TICKS  clk cycles each melody note is held (>= 2)
//     CNT_W       tick counter width, 2**CNT_W > NOTE_TICKS
//
//   Optional macro: SFX_MUTE_EN. When defined, i_mute forces o_scale and
//   o_beep_en to 0 while all sequencing carries on underneath.
// ----------------------------------------------------------------------------
module sfx_scheduler #(
  parameter int NOTE_TICKS = 12500000,
  parameter int CNT_W      = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  sfx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CHARGE = 2'd1,
    S_MELODY = 2'd2
  } state_e;

  // Encoding doubles as priority: a larger value preempts a smaller one.
  typedef enum logic [1:0] {
    MEL_NONE = 2'd0,
    MEL_OK   = 2'd1,
    MEL_FAIL = 2'd2,
    MEL_GO   = 2'd3
  } mel_e;

  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(NOTE_TICKS - 1);

  function automatic logic [3:0] rom_note(mel_e m, logic [2:0] i);
    logic [3:0] n;
    n = 4'd0;
    case (m)
      MEL_OK:   case (i) 3'd0: n = 4'd5;  3'd1: n = 4'd8;  default: n = 4'd10; endcase
      MEL_FAIL: case (i) 3'd0: n = 4'd6;  default: n = 4'd3; endcase
      MEL_GO:   case (i)
                  3'd0:    n = 4'd10;
                  3'd1:    n = 4'd8;
                  3'd2:    n = 4'd6;
                  3'd3:    n = 4'd4;
                  default: n = 4'd1;
                endcase
      default:  n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] rom_last(mel_e m);
    logic [2:0] l;
    case (m)
      MEL_OK:   l = 3'd2;
      MEL_FAIL: l = 3'd1;
      MEL_GO:   l = 3'd4;
      default:  l = 3'd0;
    endcase
    return l;
  endfunction

  state_e           state_q;
  mel_e             mel_q;
  logic [2:0]       idx_q;
  logic [CNT_W-1:0] tick_q;
  logic [3:0]       scale_q;
  logic             beep_q;
  logic             busy_q;
  logic [1:0]       src_q;

  // Highest-priority pulse this cycle; lower simultaneous pulses are dropped.
  mel_e       pulse_mel;
  // Where to land when no melody is playing: charge tone or silence.
  state_e     rest_state;
  logic [3:0] rest_scale;
  logic       rest_beep;
  logic [1:0] rest_src;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pulse_mel = MEL_NONE;
    if (bus.i_gameover)       pulse_mel = MEL_GO;
    else if (bus.i_land_fail) pulse_mel = MEL_FAIL;
    else if (bus.i_land_ok)   pulse_mel = MEL_OK;
  end

  always_comb begin
    rest_state = S_IDLE;
    rest_scale = 4'd0;
    rest_beep  = 1'b0;
    rest_src   = 2'd0;
    if (bus.i_charge) begin
      rest_state = S_CHARGE;
      // Shift of the full 4-bit level: 15 maps to 7 without special casing.
      rest_scale = 4'(bus.i_charge_lvl >> 1);
      rest_beep  = |rest_scale;
      rest_src   = 2'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mel_q   <= MEL_NONE;
      idx_q   <= 3'd0;
      tick_q  <= '0;
      scale_q <= 4'd0;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      src_q   <= 2'd0;
    end else begin
      if ((state_q != S_MELODY && pulse_mel != MEL_NONE) ||
          (state_q == S_MELODY && pulse_mel > mel_q)) begin
        // Start or preempt: note 0 of the new ROM appears next cycle.
        state_q <= S_MELODY;
        mel_q   <= pulse_mel;
        idx_q   <= 3'd0;
        tick_q  <= '0;
        scale_q <= rom_note(pulse_mel, 3'd0);
        beep_q  <= 1'b1;
        busy_q  <= 1'b1;
        src_q   <= (pulse_mel == MEL_GO) ? 2'd3 : 2'd2;
      end else if (state_q == S_MELODY) begin
        if (tick_q == LAST_TICK) begin
          tick_q <= '0;
          if (idx_q == rom_last(mel_q)) begin
            // Melody done: drop straight into charge tone or silence.
            state_q <= rest_state;
            mel_q   <= MEL_NONE;
            idx_q   <= 3'd0;
            scale_q <= rest_scale;
            beep_q  <= rest_beep;
            busy_q  <= 1'b0;
            src_q   <= rest_src;
          end else begin
            idx_q   <= idx_q + 3'd1;
            scale_q <= rom_note(mel_q, idx_q + 3'd1);
          end
        end else begin
          tick_q <= tick_q + CNT_W'(1);
        end
      end else begin
        // IDLE / CHARGE: re-register the charge tone every cycle.
        state_q <= rest_state;
        mel_q   <= MEL_NONE;
        idx_q   <= 3'd0;
        tick_q  <= '0;
        scale_q <= rest_scale;
        beep_q  <= rest_beep;
        busy_q  <= 1'b0;
        src_q   <= rest_src;
      end
    end
  end

`ifdef SFX_MUTE_EN
  // Mute only masks what reaches the buzzer; sequencing continues so that
  // unmuting resumes at the current note.
  assign bus.o_scale   = bus.i_mute ? 4'd0 : scale_q;
  assign bus.o_beep_en = beep_q & ~bus.i_mute;
`else
  assign bus.o_scale   = scale_q;
  assign bus.o_beep_en = beep_q;
`endif
  assign bus.o_busy    = busy_q;
  assign bus.o_src     = src_q;

endmodule
